// File: rtl/cache_pkg.sv
// Shared types and field widths for the direct-mapped write-back cache.
// Word select/merge helper keeps block-offset arithmetic in one place.
package cache_pkg;
   localparam int ADDR_W          = 30;
   localparam int WORD_W          = 32;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int OFFSET_W        = 2;
   localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
   localparam int BLK_ADDR_W      = ADDR_W - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   function automatic logic [BLOCK_W-1:0] merge_word(input logic [BLOCK_W-1:0] line,
                                                     input logic [OFFSET_W-1:0] off,
                                                     input logic [WORD_W-1:0]   wdat);
      logic [BLOCK_W-1:0] r;
      r = line;
      r[off*WORD_W +: WORD_W] = wdat;
      return r;
   endfunction
endpackage

// File: rtl/cache_line_array.sv
// Line storage: per-set valid/dirty (async reset), tag and 128-bit data.
// Combinational read port, single synchronous write port (full line).
module cache_line_array
   import cache_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int INDEX_W  = 3,
   parameter int TAG_W    = 25
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] rd_idx_i,
   output logic               rd_valid_o,
   output logic               rd_dirty_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [BLOCK_W-1:0] rd_data_o,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  logic               wr_valid_i,
   input  logic               wr_dirty_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [BLOCK_W-1:0] wr_data_i
);
   logic [NUM_SETS-1:0] valid_q;
   logic [NUM_SETS-1:0] dirty_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [BLOCK_W-1:0]  data_q [NUM_SETS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
         dirty_q[wr_idx_i] <= wr_dirty_i;
      end
   end

   // Tag/data need no reset: they are qualified by valid.
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back write-allocate cache: hits complete in the request cycle,
// misses stall the core through an optional write-back and a block refill.
module dcache_direct_wb
   import cache_pkg::*;
#(
   parameter int NUM_SETS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  proc_read_i,
   input  logic                  proc_write_i,
   input  logic [ADDR_W-1:0]     proc_addr_i,
   input  logic [WORD_W-1:0]     proc_wdata_i,
   output logic                  proc_stall_o,
   output logic [WORD_W-1:0]     proc_rdata_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [BLK_ADDR_W-1:0] mem_addr_o,
   output logic [BLOCK_W-1:0]    mem_wdata_o,
   input  logic [BLOCK_W-1:0]    mem_rdata_i,
   input  logic                  mem_ready_i
);
   localparam int INDEX_W = $clog2(NUM_SETS);
   localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;

   state_e                state_q, state_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [BLK_ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic [OFFSET_W-1:0] off;
   logic [INDEX_W-1:0]  idx, rd_idx;
   logic [TAG_W-1:0]    tag;
   logic                req, hit;

   logic                rd_valid, rd_dirty;
   logic [TAG_W-1:0]    rd_tag;
   logic [BLOCK_W-1:0]  rd_data;
   logic                we, wr_valid, wr_dirty;
   logic [TAG_W-1:0]    wr_tag;
   logic [INDEX_W-1:0]  wr_idx;
   logic [BLOCK_W-1:0]  wr_data;

   assign off = proc_addr_i[OFFSET_W-1:0];
   assign idx = proc_addr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign tag = proc_addr_i[ADDR_W-1:INDEX_W+OFFSET_W];
   assign req = proc_read_i | proc_write_i;
   assign hit = req & rd_valid & (rd_tag == tag);

   // While a miss is in flight the line is addressed from the latched block
   // address, so write-back data and the fill target survive a dropped request.
   assign rd_idx = (state_q == IDLE) ? idx : mem_addr_q[INDEX_W-1:0];

   cache_line_array #(
      .NUM_SETS (NUM_SETS),
      .INDEX_W  (INDEX_W),
      .TAG_W    (TAG_W)
   ) u_lines (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (rd_idx),
      .rd_valid_o (rd_valid),
      .rd_dirty_o (rd_dirty),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .we_i       (we),
      .wr_idx_i   (wr_idx),
      .wr_valid_i (wr_valid),
      .wr_dirty_i (wr_dirty),
      .wr_tag_i   (wr_tag),
      .wr_data_i  (wr_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      proc_stall_o = 1'b0;
      proc_rdata_o = '0;
      we           = 1'b0;
      wr_idx       = rd_idx;
      wr_valid     = rd_valid;
      wr_dirty     = rd_dirty;
      wr_tag       = rd_tag;
      wr_data      = rd_data;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  if (proc_write_i) begin
                     we       = 1'b1;
                     wr_dirty = 1'b1;
                     wr_data  = merge_word(rd_data, off, proc_wdata_i);
                  end else begin
                     proc_rdata_o = rd_data[off*WORD_W +: WORD_W];
                  end
               end else begin
                  proc_stall_o = 1'b1;
                  if (rd_valid && rd_dirty) begin
                     state_d     = WRITEBACK;
                     mem_write_d = 1'b1;
                     mem_addr_d  = {rd_tag, idx};
                  end else begin
                     state_d    = ALLOCATE;
                     mem_read_d = 1'b1;
                     mem_addr_d = proc_addr_i[ADDR_W-1:OFFSET_W];
                  end
               end
            end
         end
         WRITEBACK: begin
            proc_stall_o = 1'b1;
            if (mem_ready_i) begin
               we          = 1'b1;
               wr_dirty    = 1'b0;
               mem_write_d = 1'b0;
               if (req) begin
                  state_d    = ALLOCATE;
                  mem_read_d = 1'b1;
                  mem_addr_d = proc_addr_i[ADDR_W-1:OFFSET_W];
               end else begin
                  state_d = IDLE;
               end
            end
         end
         ALLOCATE: begin
            proc_stall_o = 1'b1;
            if (mem_ready_i) begin
               we         = 1'b1;
               wr_valid   = 1'b1;
               wr_dirty   = 1'b0;
               wr_tag     = mem_addr_q[BLK_ADDR_W-1:INDEX_W];
               wr_data    = mem_rdata_i;
               mem_read_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_read_o  = mem_read_q;
   assign mem_write_o = mem_write_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = rd_data;
endmodule

// File: tb/tb_dcache_direct_wb.sv
// Bench for dcache_direct_wb: directed requests, a latency-programmable memory
// responder, and queue-based scoreboards for core responses and memory requests.
module tb_dcache_direct_wb;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read, proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready;

   typedef struct {
      bit          is_wr;
      logic [31:0] rdata;
   } core_exp_t;

   typedef struct {
      bit           is_wr;
      logic [27:0]  addr;
      logic [127:0] wdata;
   } mem_exp_t;

   core_exp_t    core_q[$];
   mem_exp_t     memx_q[$];
   logic [127:0] mem_model [int];
   int           checks = 0;
   int           errors = 0;
   int           lat = 5;
   bit           both_high = 0;

   always #5 clk = ~clk;

   dcache_direct_wb dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .proc_read_i  (proc_read),
      .proc_write_i (proc_write),
      .proc_addr_i  (proc_addr),
      .proc_wdata_i (proc_wdata),
      .proc_stall_o (proc_stall),
      .proc_rdata_o (proc_rdata),
      .mem_read_o   (mem_read),
      .mem_write_o  (mem_write),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata),
      .mem_ready_i  (mem_ready)
   );

   function automatic logic [127:0] blk(input logic [31:0] w3, w2, w1, w0);
      return {w3, w2, w1, w0};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: mem_ready pulses in the lat-th cycle of a request.
   initial begin
      bit aborted;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && (mem_read || mem_write)) begin
            aborted = 0;
            for (int k = 0; k < lat - 1; k++) begin
               @(posedge clk);
               if (!rst_n) begin
                  aborted = 1;
                  break;
               end
            end
            if (!aborted) begin
               #1;
               if (mem_write) mem_model[int'(mem_addr)] = mem_wdata;
               else mem_rdata = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : '0;
               mem_ready = 1'b1;
               @(posedge clk);
               #1 mem_ready = 1'b0;
            end
         end
      end
   end

   // Core-side monitor: every completed request pops one expectation.
   always @(negedge clk) begin
      if (rst_n && (proc_read || proc_write) && !proc_stall) begin
         core_exp_t e;
         if (core_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL core_unexpected: response at addr %h with empty queue", proc_addr);
         end else begin
            e = core_q.pop_front();
            if (e.is_wr) check("core_kind_write", {127'd0, proc_write}, 128'd1);
            else check($sformatf("rdata_%h", proc_addr), {96'd0, proc_rdata}, {96'd0, e.rdata});
         end
      end
   end

   // Memory-side monitor: compares each new request and its stability.
   logic         prev_rd = 0, prev_wr = 0, stable_ok = 1;
   logic [27:0]  lat_addr;
   logic [127:0] lat_wdata;
   always @(negedge clk) begin
      if (mem_read && mem_write) both_high = 1;
      if ((mem_read && !prev_rd) || (mem_write && !prev_wr)) begin
         mem_exp_t e;
         lat_addr  = mem_addr;
         lat_wdata = mem_wdata;
         stable_ok = 1;
         if (memx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: rd=%0d wr=%0d addr=%h", mem_read, mem_write, mem_addr);
         end else begin
            e = memx_q.pop_front();
            check("mem_kind", {127'd0, mem_write}, {127'd0, e.is_wr});
            check("mem_addr", {100'd0, mem_addr}, {100'd0, e.addr});
            if (e.is_wr) check("mem_wdata", mem_wdata, e.wdata);
         end
      end else if (mem_read || mem_write) begin
         if (mem_addr !== lat_addr || (mem_write && mem_wdata !== lat_wdata)) stable_ok = 0;
      end else if (prev_rd || prev_wr) begin
         check("mem_stable", {127'd0, stable_ok}, 128'd1);
      end
      prev_rd = mem_read;
      prev_wr = mem_write;
   end

   task automatic do_req(input bit wr, input logic [29:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input int exp_stall);
      int n;
      core_q.push_back('{is_wr: wr, rdata: exp_rdata});
      @(posedge clk);
      #1;
      proc_read  = !wr;
      proc_write = wr;
      proc_addr  = addr;
      proc_wdata = wdata;
      n = 0;
      forever begin
         @(negedge clk);
         if (!proc_stall) break;
         n++;
         if (n > 200) break;
      end
      check($sformatf("stall_cycles_%h", addr), 128'(n), 128'(exp_stall));
      @(posedge clk);
      #1;
      proc_read  = 0;
      proc_write = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
      mem_model[4]  = blk(32'h4444, 32'h3333, 32'h2222, 32'h1111);
      mem_model[12] = blk(32'hC3, 32'hC2, 32'hC1, 32'hC0);
      mem_model[8]  = blk(32'h8883, 32'h8882, 32'h8881, 32'h8880);
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_read",  {127'd0, mem_read},   128'd0);
      check("rst_mem_write", {127'd0, mem_write},  128'd0);
      check("rst_stall",     {127'd0, proc_stall}, 128'd0);
      check("rst_rdata",     {96'd0, proc_rdata},  128'd0);
      rst_n = 1;

      lat = 5;
      memx_q.push_back('{is_wr: 0, addr: 28'h4, wdata: '0});
      do_req(0, 30'h10, 0, 32'h1111, 6);
      do_req(0, 30'h11, 0, 32'h2222, 0);
      do_req(1, 30'h12, 32'hDEADBEEF, 0, 0);
      do_req(0, 30'h12, 0, 32'hDEADBEEF, 0);

      lat = 3;
      memx_q.push_back('{is_wr: 1, addr: 28'h4, wdata: blk(32'h4444, 32'hDEADBEEF, 32'h2222, 32'h1111)});
      memx_q.push_back('{is_wr: 0, addr: 28'hC, wdata: '0});
      do_req(0, 30'h30, 0, 32'hC0, 7);

      lat = 20;
      memx_q.push_back('{is_wr: 0, addr: 28'h4, wdata: '0});
      @(posedge clk);
      #1;
      proc_read = 1;
      proc_addr = 30'h10;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mem_read) break;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 0;
      #1 check("rst_inflight_mem_read", {127'd0, mem_read}, 128'd0);
      proc_read = 0;
      #1 check("rst_inflight_stall", {127'd0, proc_stall}, 128'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      lat = 4;
      memx_q.push_back('{is_wr: 0, addr: 28'h4, wdata: '0});
      do_req(0, 30'h10, 0, 32'h1111, 5);

      lat = 2;
      memx_q.push_back('{is_wr: 0, addr: 28'h8, wdata: '0});
      do_req(1, 30'h20, 32'hCAFEF00D, 0, 3);
      do_req(0, 30'h20, 0, 32'hCAFEF00D, 0);
      do_req(0, 30'h21, 0, 32'h8881, 0);
      do_req(0, 30'h22, 0, 32'h8882, 0);
      do_req(0, 30'h23, 0, 32'h8883, 0);
      do_req(0, 30'h10, 0, 32'h1111, 0);

      repeat (4) @(posedge clk);
      check("never_both_high",   {127'd0, both_high},  128'd0);
      check("core_queue_empty",  128'(core_q.size()),  128'd0);
      check("mem_queue_empty",   128'(memx_q.size()),  128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
